// File: rtl/rate_select_tick_gen_if.sv
// Button inputs and tick/rate status outputs of the rate-select tick generator.
// The design drives tick/rate/led_rate through the slave modport; the stimulus side uses master.
interface rate_select_tick_gen_if;
    logic       btn_faster;
    logic       btn_slower;
    logic       tick;
    logic [1:0] rate;
    logic [3:0] led_rate;

    modport master (output btn_faster, output btn_slower,
                    input  tick, input rate, input led_rate);
    modport slave  (input  btn_faster, input btn_slower,
                    output tick, output rate, output led_rate);
endinterface

// File: rtl/rate_select_tick_gen.sv
// Debounces two buttons, steps a 1/2/4/8 Hz rate FSM and emits a registered one-cycle tick at that rate.
// Button->rate: 2 sync + DEB_LEN..DEB_LEN+1 sample periods + 2 cycles; no backpressure, tick is a bare pulse.
module rate_select_tick_gen #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int DEB_DIV = 100_000,
    parameter int DEB_LEN = 4
) (
    input logic                   clk,
    input logic                   rst,
    rate_select_tick_gen_if.slave bus
);
    localparam int              DIV_W    = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DEB_DIV - 1);
    localparam logic [31:0]     P1HZ     = 32'(CLK_HZ);
    localparam logic [31:0]     P2HZ     = 32'(CLK_HZ / 2);
    localparam logic [31:0]     P4HZ     = 32'(CLK_HZ / 4);
    localparam logic [31:0]     P8HZ     = 32'(CLK_HZ / 8);

    typedef enum logic [1:0] {S1HZ = 2'd0, S2HZ = 2'd1, S4HZ = 2'd2, S8HZ = 2'd3} rate_e;

    // Bit 0 carries btn_faster, bit 1 carries btn_slower throughout the input path.
    logic [1:0]         sync1_q, sync2_q;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               samp;
    logic [DEB_LEN-1:0] shf_q, shf_d, shs_q, shs_d;
    logic [1:0]         deb_q, deb_d, deb_hist_q, press_q, press_d;
    rate_e              state_q;
    logic [31:0]        period, cnt_q, cnt_d;
    logic               tick_q, tick_d;
    logic               step_up, step_dn, rate_chg;

    always_comb begin
        samp    = (div_q == DIV_LAST);
        div_d   = samp ? '0 : div_q + 1'b1;
        shf_d   = samp ? {shf_q[DEB_LEN-2:0], sync2_q[0]} : shf_q;
        shs_d   = samp ? {shs_q[DEB_LEN-2:0], sync2_q[1]} : shs_q;
        deb_d   = deb_q;
        if (&shf_q)       deb_d[0] = 1'b1;
        else if (~|shf_q) deb_d[0] = 1'b0;
        if (&shs_q)       deb_d[1] = 1'b1;
        else if (~|shs_q) deb_d[1] = 1'b0;
        press_d = deb_q & ~deb_hist_q;
    end

    assign step_up  = press_q[0] & ~press_q[1];
    assign step_dn  = press_q[1] & ~press_q[0];
    // Only a step that actually moves the rate restarts the period counter.
    assign rate_chg = (step_up && (state_q != S8HZ)) || (step_dn && (state_q != S1HZ));

    always_comb begin
        period = P1HZ;
        case (state_q)
            S1HZ: period = P1HZ;
            S2HZ: period = P2HZ;
            S4HZ: period = P4HZ;
            S8HZ: period = P8HZ;
            default: period = P1HZ;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q + 32'd1;
        tick_d = 1'b0;
        if (rate_chg) begin
            cnt_d = '0;
        end else if (cnt_q == period - 32'd1) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            div_q      <= '0;
            shf_q      <= '0;
            shs_q      <= '0;
            deb_q      <= '0;
            deb_hist_q <= '0;
            press_q    <= '0;
            cnt_q      <= '0;
            tick_q     <= 1'b0;
        end else begin
            sync1_q    <= {bus.btn_slower, bus.btn_faster};
            sync2_q    <= sync1_q;
            div_q      <= div_d;
            shf_q      <= shf_d;
            shs_q      <= shs_d;
            deb_q      <= deb_d;
            deb_hist_q <= deb_q;
            press_q    <= press_d;
            cnt_q      <= cnt_d;
            tick_q     <= tick_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S1HZ;
        end else begin
            case (state_q)
                S1HZ: if (step_up) state_q <= S2HZ;
                S2HZ: if (step_up) state_q <= S4HZ; else if (step_dn) state_q <= S1HZ;
                S4HZ: if (step_up) state_q <= S8HZ; else if (step_dn) state_q <= S2HZ;
                S8HZ: if (step_dn) state_q <= S4HZ;
                default: state_q <= S1HZ;
            endcase
        end
    end

    assign bus.tick     = tick_q;
    assign bus.rate     = state_q;
    assign bus.led_rate = 4'b0001 << state_q;
endmodule

// File: tb/tb_rate_select_tick_gen.sv
// Randomised and directed bench for rate_select_tick_gen against an event-timing reference model.
module tb_rate_select_tick_gen;
    localparam int CLK_HZ  = 16;
    localparam int DEB_DIV = 2;
    localparam int DEB_LEN = 4;
    localparam int HN      = 8192;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    rate_select_tick_gen_if bus();

    rate_select_tick_gen #(.CLK_HZ(CLK_HZ), .DEB_DIV(DEB_DIV), .DEB_LEN(DEB_LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: m_k counts edges since reset. Raw levels are logged per edge, a
    // sample window holds the last DEB_LEN sampled levels (a level seen at edge j is
    // sampled two edges later), a settled-level rise turns into a rate step three
    // edges on, and ticks fall every PERIOD edges after the last restart.
    int m_k = 0, m_last = 0, m_rate = 0;
    bit m_tick = 1'b0;
    bit bf_h [HN];
    bit bs_h [HN];
    bit lf_h [HN];
    bit ls_h [HN];
    bit qf [$];
    bit qs [$];
    bit m_pf, m_ps, m_chg, a1f, a0f, a1s, a0s;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_k = 0; m_last = 0; m_rate = 0; m_tick = 1'b0;
            qf.delete(); qs.delete();
            for (int i = 0; i < DEB_LEN; i++) begin qf.push_back(1'b0); qs.push_back(1'b0); end
            bf_h[0] = 1'b0; bs_h[0] = 1'b0; lf_h[0] = 1'b0; ls_h[0] = 1'b0;
        end else begin
            m_k++;
            bf_h[m_k % HN] = bus.btn_faster;
            bs_h[m_k % HN] = bus.btn_slower;
            if (m_k >= 2 && ((m_k - 1) % DEB_DIV) == DEB_DIV - 1) begin
                qf.push_back(bf_h[(m_k - 2) % HN]); void'(qf.pop_front());
                qs.push_back(bs_h[(m_k - 2) % HN]); void'(qs.pop_front());
            end
            a1f = 1'b1; a0f = 1'b1; a1s = 1'b1; a0s = 1'b1;
            foreach (qf[i]) begin a1f &= qf[i]; a0f &= !qf[i]; end
            foreach (qs[i]) begin a1s &= qs[i]; a0s &= !qs[i]; end
            lf_h[m_k % HN] = a1f ? 1'b1 : (a0f ? 1'b0 : lf_h[(m_k - 1) % HN]);
            ls_h[m_k % HN] = a1s ? 1'b1 : (a0s ? 1'b0 : ls_h[(m_k - 1) % HN]);
            m_pf = (m_k >= 4) && lf_h[(m_k - 3) % HN] && !lf_h[(m_k - 4) % HN];
            m_ps = (m_k >= 4) && ls_h[(m_k - 3) % HN] && !ls_h[(m_k - 4) % HN];
            m_chg = 1'b0;
            if (m_pf && !m_ps && m_rate < 3)      begin m_rate++; m_chg = 1'b1; end
            else if (m_ps && !m_pf && m_rate > 0) begin m_rate--; m_chg = 1'b1; end
            if (m_chg) begin
                m_tick = 1'b0;
                m_last = m_k;
            end else begin
                m_tick = ((m_k - m_last) % (CLK_HZ >> m_rate)) == 0;
            end
        end
    end

    task automatic press(input logic f, input logic s, input int hi, input int lo);
        for (int c = 0; c < hi + lo; c++) begin
            bus.btn_faster = (c < hi) ? f : 1'b0;
            bus.btn_slower = (c < hi) ? s : 1'b0;
            @(negedge clk);
            n_cmp++; if (bus.tick !== m_tick) begin n_bad++; $display("FAIL press_tick k=%0d got %b want %b", m_k, bus.tick, m_tick); end
            n_cmp++; if (bus.rate !== 2'(m_rate)) begin n_bad++; $display("FAIL press_rate k=%0d got %0d want %0d", m_k, bus.rate, m_rate); end
        end
    endtask

    task automatic idle(input int n, input int gap);
        int lastt = -1;
        bus.btn_faster = 1'b0;
        bus.btn_slower = 1'b0;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            n_cmp++; if (bus.tick !== m_tick) begin n_bad++; $display("FAIL idle_tick k=%0d got %b want %b", m_k, bus.tick, m_tick); end
            n_cmp++; if (bus.led_rate !== (4'b0001 << m_rate)) begin n_bad++; $display("FAIL idle_led k=%0d got %b want %b", m_k, bus.led_rate, 4'b0001 << m_rate); end
            if (gap > 0 && bus.tick === 1'b1) begin
                if (lastt >= 0) begin
                    n_cmp++; if (c - lastt != gap) begin n_bad++; $display("FAIL idle_gap got %0d want %0d", c - lastt, gap); end
                end
                lastt = c;
            end
        end
    endtask

    task automatic test_reset();
        bus.btn_faster = 1'b0;
        bus.btn_slower = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.tick !== 1'b0)        begin n_bad++; $display("FAIL reset_tick got %b want 0", bus.tick); end
        n_cmp++; if (bus.rate !== 2'd0)        begin n_bad++; $display("FAIL reset_rate got %0d want 0", bus.rate); end
        n_cmp++; if (bus.led_rate !== 4'b0001) begin n_bad++; $display("FAIL reset_led got %b want 0001", bus.led_rate); end
        rst = 1'b0;
    endtask

    task automatic test_baseline();
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            n_cmp++; if (bus.tick !== ((c % 16) == 0)) begin n_bad++; $display("FAIL base_tick cycle=%0d got %b want %b", c, bus.tick, (c % 16) == 0); end
            n_cmp++; if (bus.tick !== m_tick) begin n_bad++; $display("FAIL base_model cycle=%0d got %b want %b", c, bus.tick, m_tick); end
            n_cmp++; if (bus.led_rate !== 4'b0001) begin n_bad++; $display("FAIL base_led cycle=%0d got %b want 0001", c, bus.led_rate); end
        end
    endtask

    task automatic test_hold_faster();
        int rc = -1, lastt = -1, nchg = 0;
        logic [1:0] prev = 2'd0;
        for (int c = 1; c <= 240; c++) begin
            bus.btn_faster = (c <= 200);
            @(negedge clk);
            n_cmp++; if (bus.tick !== m_tick) begin n_bad++; $display("FAIL hold_tick k=%0d got %b want %b", m_k, bus.tick, m_tick); end
            n_cmp++; if (bus.rate !== 2'(m_rate)) begin n_bad++; $display("FAIL hold_rate k=%0d got %0d want %0d", m_k, bus.rate, m_rate); end
            if (bus.rate !== prev) begin nchg++; rc = c; prev = bus.rate; end
            if (bus.tick === 1'b1 && rc > 0) begin
                n_cmp++; if (c - ((lastt < 0) ? rc : lastt) != 8) begin n_bad++; $display("FAIL hold_gap got %0d want 8", c - ((lastt < 0) ? rc : lastt)); end
                lastt = c;
            end
        end
        n_cmp++; if (nchg != 1)                begin n_bad++; $display("FAIL hold_steps got %0d want 1", nchg); end
        n_cmp++; if (bus.rate !== 2'd1)        begin n_bad++; $display("FAIL hold_final_rate got %0d want 1", bus.rate); end
        n_cmp++; if (bus.led_rate !== 4'b0010) begin n_bad++; $display("FAIL hold_led got %b want 0010", bus.led_rate); end
    endtask

    task automatic test_saturate();
        repeat (5) press(1'b1, 1'b0, 40, 40);
        n_cmp++; if (bus.rate !== 2'd3)        begin n_bad++; $display("FAIL sat_rate got %0d want 3", bus.rate); end
        n_cmp++; if (bus.led_rate !== 4'b1000) begin n_bad++; $display("FAIL sat_led got %b want 1000", bus.led_rate); end
        idle(20, 2);
        repeat (4) press(1'b0, 1'b1, 40, 40);
        n_cmp++; if (bus.rate !== 2'd0)        begin n_bad++; $display("FAIL slow_rate got %0d want 0", bus.rate); end
        idle(70, 16);
    endtask

    task automatic test_toggle();
        // High only on edges the shared sample divider never picks up.
        for (int c = 0; c < 30; c++) begin
            bus.btn_faster = 1'((m_k + 1) % 2);
            @(negedge clk);
            n_cmp++; if (bus.tick !== m_tick) begin n_bad++; $display("FAIL tog_tick k=%0d got %b want %b", m_k, bus.tick, m_tick); end
        end
        idle(80, 16);
        n_cmp++; if (bus.rate !== 2'd0) begin n_bad++; $display("FAIL tog_rate got %0d want 0", bus.rate); end
    endtask

    task automatic test_both();
        press(1'b1, 1'b0, 40, 40);
        press(1'b1, 1'b1, 100, 60);
        n_cmp++; if (bus.rate !== 2'd1) begin n_bad++; $display("FAIL both_rate got %0d want 1", bus.rate); end
        idle(40, 8);
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int sel = $urandom_range(0, 2);
            logic f = (sel != 1);
            logic s = (sel != 0);
            for (int ph = 0; ph < 2; ph++) begin
                int nb = $urandom_range(0, 10);
                for (int c = 0; c < nb; c++) begin
                    bus.btn_faster = f & 1'($urandom_range(0, 1));
                    bus.btn_slower = s & 1'($urandom_range(0, 1));
                    @(negedge clk);
                    n_cmp++; if (bus.tick !== m_tick) begin n_bad++; $display("FAIL rnd_tick k=%0d got %b want %b", m_k, bus.tick, m_tick); end
                    n_cmp++; if (bus.rate !== 2'(m_rate)) begin n_bad++; $display("FAIL rnd_rate k=%0d got %0d want %0d", m_k, bus.rate, m_rate); end
                end
                if (ph == 0) press(f, s, $urandom_range(25, 45), 0);
                else         press(1'b0, 1'b0, 0, $urandom_range(30, 45));
            end
        end
    endtask

    task automatic test_reset_mid();
        int first = -1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        press(1'b1, 1'b0, 40, 40);
        press(1'b1, 1'b0, 40, 40);
        n_cmp++; if (bus.rate !== 2'd2) begin n_bad++; $display("FAIL mid_pre_rate got %0d want 2", bus.rate); end
        idle($urandom_range(1, 3), 0);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bus.tick !== 1'b0)        begin n_bad++; $display("FAIL mid_tick got %b want 0", bus.tick); end
        n_cmp++; if (bus.rate !== 2'd0)        begin n_bad++; $display("FAIL mid_rate got %0d want 0", bus.rate); end
        n_cmp++; if (bus.led_rate !== 4'b0001) begin n_bad++; $display("FAIL mid_led got %b want 0001", bus.led_rate); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            n_cmp++; if (bus.tick !== m_tick) begin n_bad++; $display("FAIL mid_model k=%0d got %b want %b", m_k, bus.tick, m_tick); end
            if (bus.tick === 1'b1 && first < 0) first = c;
        end
        n_cmp++; if (first != 16) begin n_bad++; $display("FAIL mid_first_tick got %0d want 16 (-1 = none within 40 cycles)", first); end
    endtask

    initial begin
        test_reset();
        test_baseline();
        test_hold_faster();
        test_saturate();
        test_toggle();
        test_both();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
